// File: rtl/inst_fetch_queue_pkg.sv
// Shared bus widths for the fetch -> launch boundary and queue occupancy sizing.
package inst_fetch_queue_pkg;
  localparam int LaneWidth      = 64;             // {pc[31:0], inst[31:0]}
  localparam int IfToIdBusWidth = 2 * LaneWidth;  // {lane2, lane1}

  function automatic int fq_count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Occupancy width for monitors of the default 8-entry queue.
  localparam int FqCountWidth = fq_count_w(8);
endpackage

// File: rtl/inst_fetch_queue.sv
// Dual-lane instruction queue: takes up to two fetched instructions per cycle,
// presents the two oldest to launch, retires 0/1/2 per cycle, flushes on redirect.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int LANE_W = LaneWidth
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                line1_pre_to_now_valid_i,
  input  logic                line2_pre_to_now_valid_i,
  input  logic [2*LANE_W-1:0] pre_to_ibus,
  output logic                now_allowin_o,
  input  logic                next_allowin_i,
  input  logic                lunch_stall_i,
  output logic                line1_now_to_next_valid_o,
  output logic                line2_now_to_next_valid_o,
  output logic [2*LANE_W-1:0] to_next_obus,
  input  logic                branch_flush_i,
  input  logic                excep_flush_i
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [LANE_W-1:0] mem [DEPTH];
  logic [PW-1:0]     head, tail, head_nx1, tail_l2;
  logic [CW-1:0]     count;
  logic [1:0]        push, pop;
  logic              fire, v1, v2, flush;
  logic              in1, in2;

  assign in1   = line1_pre_to_now_valid_i;
  assign in2   = line2_pre_to_now_valid_i;
  assign flush = branch_flush_i | excep_flush_i;

  // Admission looks only at registered count; a same-cycle pop earns no credit.
  assign now_allowin_o = (count <= CW'(DEPTH - 2));
  assign v1            = (count != '0);
  assign v2            = (count >= CW'(2));
  assign head_nx1      = head + PW'(1);

  assign fire = now_allowin_o & (in1 | in2);
  assign push = fire ? ({1'b0, in1} + {1'b0, in2}) : 2'd0;
  // A lone lane 2 lands in the tail slot so the queue stays dense.
  assign tail_l2 = in1 ? tail + PW'(1) : tail;

  always_comb begin
    pop = 2'd0;
    if (next_allowin_i && v1) begin
      if (lunch_stall_i || !v2) pop = 2'd1;
      else                      pop = 2'd2;
    end
  end

  assign line1_now_to_next_valid_o = v1;
  assign line2_now_to_next_valid_o = v2;
  assign to_next_obus = {v2 ? mem[head_nx1] : {LANE_W{1'b0}},
                         v1 ? mem[head]     : {LANE_W{1'b0}}};

  // Payload storage needs no reset: outputs are gated by the valids.
  always_ff @(posedge clk) begin
    if (fire) begin
      if (in1) mem[tail]    <= pre_to_ibus[LANE_W-1:0];
      if (in2) mem[tail_l2] <= pre_to_ibus[2*LANE_W-1:LANE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop);
      tail  <= tail + PW'(push);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue (DEPTH=8): reset, stall, full, wrap, flush.
module tb_inst_fetch_queue;
  localparam int LW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          l1_v, l2_v, na, st, bf, ef;
  logic [2*LW-1:0] ibus;
  logic          allowin, o1_v, o2_v;
  logic [2*LW-1:0] obus;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(8), .LANE_W(LW)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .line1_pre_to_now_valid_i  (l1_v),
    .line2_pre_to_now_valid_i  (l2_v),
    .pre_to_ibus               (ibus),
    .now_allowin_o             (allowin),
    .next_allowin_i            (na),
    .lunch_stall_i             (st),
    .line1_now_to_next_valid_o (o1_v),
    .line2_now_to_next_valid_o (o2_v),
    .to_next_obus              (obus),
    .branch_flush_i            (bf),
    .excep_flush_i             (ef)
  );

  function automatic logic [LW-1:0] ent(input int n);
    logic [31:0] pc, in;
    pc = 32'h1c00_0000 + 32'(4 * n);
    in = 32'h0280_0000 | 32'(n);
    return {pc, in};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs, then inputs idle; sample 1ns after the edge.
  task automatic tick(input logic a1, input logic a2, input logic [LW-1:0] d1,
                      input logic [LW-1:0] d2, input logic nai, input logic sti,
                      input logic bfi, input logic efi);
    l1_v = a1; l2_v = a2; ibus = {d2, d1}; na = nai; st = sti; bf = bfi; ef = efi;
    @(posedge clk);
    #1;
    l1_v = 1'b0; l2_v = 1'b0; ibus = '0; na = 1'b0; st = 1'b0; bf = 1'b0; ef = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic e1, input logic e2,
                         input logic [LW-1:0] d1, input logic [LW-1:0] d2, input logic ea);
    chk({tag, ".vld"}, {126'd0, o1_v, o2_v}, {126'd0, e1, e2});
    chk({tag, ".bus"}, obus, {d2, d1});
    chk({tag, ".allowin"}, {127'd0, allowin}, {127'd0, ea});
  endtask

  initial begin
    rst_n = 1'b0;
    l1_v = 0; l2_v = 0; ibus = '0; na = 0; st = 0; bf = 0; ef = 0;
    tick(0, 0, '0, '0, 0, 0, 0, 0);
    rst_n = 1'b1;
    chk_out("por", 0, 0, '0, '0, 1);

    // Load 3 entries, then a 1-cycle reset mid-stream.
    tick(1, 1, ent(40), ent(41), 0, 0, 0, 0);
    tick(1, 0, ent(42), '0, 0, 0, 0, 0);
    chk_out("pre_rst", 1, 1, ent(40), ent(41), 1);
    rst_n = 1'b0;
    tick(0, 0, '0, '0, 0, 0, 0, 0);
    rst_n = 1'b1;
    chk_out("rst3", 0, 0, '0, '0, 1);

    // Two pairs with launch blocked; data must hold.
    tick(1, 1, ent(0), ent(1), 0, 0, 0, 0);
    chk_out("lat1", 1, 1, ent(0), ent(1), 1);
    tick(1, 1, ent(2), ent(3), 0, 1, 0, 0);   // stall ignored without allowin
    chk_out("cnt4", 1, 1, ent(0), ent(1), 1);
    tick(0, 0, '0, '0, 0, 0, 0, 0);
    chk_out("hold", 1, 1, ent(0), ent(1), 1);

    // Single issue under stall.
    tick(0, 0, '0, '0, 1, 1, 0, 0);
    chk_out("stall1", 1, 1, ent(1), ent(2), 1);

    // Fill to 7: admission drops, lone push refused.
    tick(1, 1, ent(4), ent(5), 0, 0, 0, 0);
    chk_out("cnt5", 1, 1, ent(1), ent(2), 1);
    tick(1, 1, ent(6), ent(7), 0, 0, 0, 0);
    chk_out("full7", 1, 1, ent(1), ent(2), 0);
    tick(1, 0, ent(99), '0, 0, 0, 0, 0);
    chk_out("refused", 1, 1, ent(1), ent(2), 0);
    tick(0, 0, '0, '0, 1, 0, 0, 0);
    chk_out("pop2_c5", 1, 1, ent(3), ent(4), 1);
    tick(0, 0, '0, '0, 1, 0, 0, 0);
    chk_out("pop2_c3", 1, 1, ent(5), ent(6), 1);

    // Wrap: push 2 + pop 2 leaves head 7, count 3.
    tick(1, 1, ent(8), ent(9), 1, 0, 0, 0);
    chk_out("head7", 1, 1, ent(7), ent(8), 1);
    tick(1, 1, ent(10), ent(11), 1, 0, 0, 0);
    chk_out("wrap", 1, 1, ent(9), ent(10), 1);

    // Flush at count 5 with a simultaneous push 2 / pop 2.
    tick(1, 1, ent(12), ent(13), 0, 0, 0, 0);
    tick(1, 1, ent(20), ent(21), 1, 0, 1, 0);
    chk_out("bflush", 0, 0, '0, '0, 1);
    tick(1, 1, ent(14), ent(15), 0, 0, 0, 0);
    chk_out("post_fl", 1, 1, ent(14), ent(15), 1);
    tick(0, 0, '0, '0, 0, 0, 0, 1);
    chk_out("eflush", 0, 0, '0, '0, 1);

    // Lone lane 2 is compacted into lane 1 position.
    tick(0, 1, '0, ent(16), 0, 0, 0, 0);
    chk_out("l2only", 1, 0, ent(16), '0, 1);
    tick(0, 0, '0, '0, 1, 0, 0, 0);
    chk_out("drain", 0, 0, '0, '0, 1);
    tick(0, 0, '0, '0, 1, 0, 0, 0);        // pop on empty must not underflow
    chk_out("empty_pop", 0, 0, '0, '0, 1);
    tick(1, 1, ent(17), ent(18), 0, 0, 0, 0);
    chk_out("refill", 1, 1, ent(17), ent(18), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
